// File: rtl/mem_coef_reader.sv
// Streams a contiguous window of a distributed coefficient RAM as a valid/ready stream.
// Define MEM_COEF_READER_REVERSE_EN to present the window in descending address order.
module mem_coef_reader #(
    parameter int RAM_WIDTH     = 13,
    parameter int RAM_ADDR_BITS = 11
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [RAM_ADDR_BITS-1:0] base_addr,
    input  logic [RAM_ADDR_BITS:0]   length,
    output logic                     busy,
    output logic                     done,
    output logic [RAM_ADDR_BITS-1:0] rd_addr,
    input  logic [RAM_WIDTH-1:0]     rd_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [RAM_WIDTH-1:0]     out_data,
    output logic                     out_last
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    localparam logic [RAM_ADDR_BITS-1:0] ADDR_ONE = 1;
    localparam logic [RAM_ADDR_BITS:0]   REM_ONE  = 1;
    localparam logic [RAM_ADDR_BITS:0]   REM_ZERO = '0;

    state_t                   state_reg;
    logic [RAM_ADDR_BITS-1:0] addr_reg;
    logic [RAM_ADDR_BITS:0]   remaining_reg;
    logic                     busy_reg;
    logic                     done_reg;
    logic                     out_valid_reg;
    logic                     out_last_reg;
    logic [RAM_WIDTH-1:0]     out_data_reg;

    logic                     load_en;
    logic                     handshake;
    logic [RAM_ADDR_BITS-1:0] addr_next;
    logic [RAM_ADDR_BITS-1:0] start_addr;

    assign handshake = out_valid_reg && out_ready;
    assign load_en   = (state_reg == ST_RUN) && (remaining_reg != REM_ZERO)
                       && (!out_valid_reg || out_ready);

`ifdef MEM_COEF_READER_REVERSE_EN
    // Last address of the window; a full 2**RAM_ADDR_BITS length wraps to base-1.
    assign start_addr = base_addr + length[RAM_ADDR_BITS-1:0] - ADDR_ONE;
    assign addr_next  = addr_reg - ADDR_ONE;
`else
    assign start_addr = base_addr;
    assign addr_next  = addr_reg + ADDR_ONE;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            addr_reg      <= '0;
            remaining_reg <= '0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            out_valid_reg <= 1'b0;
            out_last_reg  <= 1'b0;
            out_data_reg  <= '0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        if (length == REM_ZERO) begin
                            done_reg <= 1'b1;
                        end else begin
                            addr_reg      <= start_addr;
                            remaining_reg <= length;
                            busy_reg      <= 1'b1;
                            state_reg     <= ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    if (load_en) begin
                        out_data_reg  <= rd_data;
                        out_valid_reg <= 1'b1;
                        out_last_reg  <= (remaining_reg == REM_ONE);
                        addr_reg      <= addr_next;
                        remaining_reg <= remaining_reg - REM_ONE;
                    end else if (handshake) begin
                        out_valid_reg <= 1'b0;
                        out_last_reg  <= 1'b0;
                    end
                    // The last beat never coincides with a load: remaining is already zero.
                    if (handshake && out_last_reg) begin
                        state_reg <= ST_FLUSH;
                    end
                end
                ST_FLUSH: begin
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b1;
                    state_reg <= ST_IDLE;
                end
                default: begin
                    busy_reg      <= 1'b0;
                    out_valid_reg <= 1'b0;
                    out_last_reg  <= 1'b0;
                    state_reg     <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy      = busy_reg;
    assign done      = done_reg;
    assign rd_addr   = addr_reg;
    assign out_valid = out_valid_reg;
    assign out_last  = out_last_reg;
    assign out_data  = out_data_reg;

endmodule

// File: tb/tb_mem_coef_reader.sv
// Directed self-checking bench for mem_coef_reader with a combinational RAM model (RAM[i]=i+100).
module tb_mem_coef_reader;

    localparam int AW = 11;
    localparam int DW = 13;
`ifdef MEM_COEF_READER_REVERSE_EN
    localparam bit REV = 1'b1;
`else
    localparam bit REV = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [AW:0]   length = '0;
    logic          busy;
    logic          done;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [DW-1:0] out_data;
    logic          out_last;

    logic [DW-1:0] ram [0:(1<<AW)-1];
    int checks = 0;
    int failures = 0;

    assign rd_data = ram[rd_addr];

    always #5 clk = ~clk;

    mem_coef_reader #(.RAM_WIDTH(DW), .RAM_ADDR_BITS(AW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .length(length),
        .busy(busy), .done(done), .rd_addr(rd_addr), .rd_data(rd_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last)
    );

    function automatic int exp_addr(input int base, input int len, input int i);
        if (REV) return (base + len - 1 - i) & 2047;
        return (base + i) & 2047;
    endfunction

    function automatic logic [31:0] ram_val(input int a);
        return (a + 100) & 8191;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input int base, input int len);
        base_addr = base[AW-1:0];
        length    = len[AW:0];
        start     = 1'b1;
        step();
        start     = 1'b0;
    endtask

    // Consumes len beats using ready pattern pat (plen bits, LSB first), then checks the done pulse.
    task automatic collect(input int base, input int len, input int pat, input int plen);
        int idx = 0;
        int cyc = 0;
        logic prev_stall = 1'b0;
        logic [DW-1:0] prev_data = '0;
        while (idx < len && cyc < 200) begin
            if (prev_stall) begin
                check("stall_valid", out_valid, 1);
                check("stall_data", out_data, prev_data);
            end
            if (out_valid) begin
                check("beat_data", out_data, ram_val(exp_addr(base, len, idx)));
                check("beat_last", out_last, (idx == len - 1) ? 1 : 0);
            end
            check("early_done", done, 0);
            out_ready  = ((pat >> (cyc % plen)) & 1) != 0;
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            if (out_valid && out_ready) idx++;
            cyc++;
            step();
        end
        check("stream_count", idx, len);
        check("post_valid", out_valid, 0);
        check("post_busy", busy, 1);
        check("post_done", done, 0);
        step();
        check("done_pulse", done, 1);
        check("done_busy", busy, 0);
        out_ready = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) ram[i] = DW'((i + 100) & 8191);

        // Reset state
        step();
        step();
        check("rst_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_addr", rd_addr, 0);
        check("rst_data", out_data, 0);
        check("rst_last", out_last, 0);
        rst_n = 1'b1;
        step();

        // 1: base=5 len=4 full rate with exact cycle timing
        out_ready = 1'b1;
        issue(5, 4);
        check("t1_busy", busy, 1);
        check("t1_lat_valid", out_valid, 0);
        check("t1_addr", rd_addr, exp_addr(5, 4, 0));
        for (int i = 0; i < 4; i++) begin
            step();
            check("t1_valid", out_valid, 1);
            check("t1_data", out_data, ram_val(exp_addr(5, 4, i)));
            check("t1_last", out_last, (i == 3) ? 1 : 0);
            check("t1_nodone", done, 0);
        end
        step();
        check("t1_drain_valid", out_valid, 0);
        check("t1_drain_done", done, 0);
        check("t1_drain_busy", busy, 1);
        step();
        check("t1_done", done, 1);
        check("t1_done_busy", busy, 0);
        step();
        check("t1_done_clear", done, 0);

        // 2: same command with ready pattern 1,0,0,1,0,1
        issue(5, 4);
        collect(5, 4, 'h29, 6);

        // 3: back-to-back command in the done cycle, wrapping past the top of the RAM
        issue(2046, 4);
        check("t3_busy", busy, 1);
        collect(2046, 4, 1, 1);
        step();

        // 4: zero length, then start during RUN ignored
        issue(9, 0);
        check("t4_zero_done", done, 1);
        check("t4_zero_busy", busy, 0);
        check("t4_zero_valid", out_valid, 0);
        step();
        check("t4_zero_done_clear", done, 0);
        check("t4_zero_valid2", out_valid, 0);
        issue(20, 3);
        base_addr = 11'd300;
        length    = 12'd5;
        start     = 1'b1;
        step();
        start     = 1'b0;
        collect(20, 3, 1, 1);
        step();
        check("t4_no_second", out_valid, 0);
        check("t4_idle", busy, 0);

        // 5: async reset after beat 2 of 6
        issue(50, 6);
        step();
        step();
        check("t5_beat2", out_data, ram_val(exp_addr(50, 6, 1)));
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_rst_valid", out_valid, 0);
        check("t5_rst_busy", busy, 0);
        check("t5_rst_addr", rd_addr, 0);
        check("t5_rst_data", out_data, 0);
        check("t5_rst_last", out_last, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("t5_rst_nodone", done, 0);
        end
        rst_n = 1'b1;
        step();
        check("t5_after_nodone", done, 0);
        check("t5_after_valid", out_valid, 0);
        issue(7, 2);
        collect(7, 2, 1, 1);
        step();

        // 6: base=10 len=3 (descending when the reverse build is selected)
        issue(10, 3);
        collect(10, 3, 'h5, 3);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mem_coef_reader.md
Name: mem_coef_reader

Overview:
Read-side streaming engine for the distributed coefficient RAMs (13-bit Rq coefficients, 2048-deep, combinational read port).
- On a start command, it drives the RAM read address over a contiguous window.
- It captures each combinational read result and emits it as a valid/ready stream to downstream arithmetic (multiplier / inversion datapath).
- It is the consumer counterpart to the RAM write-port loaders: full-rate, back-pressure safe, single done pulse.

Parameters:
RAM_WIDTH, 13, coefficient width; must match the RAM data width.
RAM_ADDR_BITS, 11, RAM address width; depth is 2**RAM_ADDR_BITS.

Ports:
clk  input  1  single clock, rising edge.
rst_n  input  1  asynchronous, active-low reset.
start  input  1  one-cycle command strobe; honoured only in IDLE.
base_addr  input  RAM_ADDR_BITS  first RAM address to read; sampled with start.
length  input  RAM_ADDR_BITS+1  number of coefficients to read, 0..2**RAM_ADDR_BITS; sampled with start.
busy  output  1  high while not in IDLE.
done  output  1  one-cycle pulse when the last beat has been accepted, or for a zero-length command.
rd_addr  output  RAM_ADDR_BITS  RAM read address; driven from a register.
rd_data  input  RAM_WIDTH  RAM combinational read data for rd_addr.
out_valid  output  1  stream data valid.
out_ready  input  1  downstream accept.
out_data  output  RAM_WIDTH  stream coefficient.
out_last  output  1  marks the final coefficient of the command; qualified by out_valid.

Behaviour:
- Reset (async, rst_n=0):
  - State returns to IDLE.
  - busy=0, done=0, out_valid=0, out_last=0, out_data=0, rd_addr=0; internal remaining counter=0.
  - Reset mid-command aborts immediately, with no done pulse and no further beats.
- States:
  - IDLE: busy=0. start=1 latches base_addr into the address register (rd_addr), latches length into the remaining counter, and moves to RUN. If length=0, the block instead goes to IDLE with done=1 on the next cycle and emits no beats.
  - RUN: busy=1.
  - Start while busy is ignored; latched values are unchanged.
- Load condition in RUN: (remaining!=0) and (out_valid==0 or out_ready==1). On each clock edge where it holds:
  - out_data <= rd_data (the current rd_addr's word).
  - out_valid <= 1.
  - out_last <= (remaining==1).
  - rd_addr <= rd_addr+1, modulo 2**RAM_ADDR_BITS; wraps from 2047 to 0.
  - remaining <= remaining-1.
- Drain: if out_valid&out_ready and the load condition is false, then out_valid <= 0 and out_last <= 0.
- Stall: out_valid=1 and out_ready=0 holds out_data, out_last and rd_addr stable.
- Completion: a handshake (out_valid&out_ready) with out_last=1 moves the block to IDLE; done=1 for exactly one cycle on the following cycle, busy=0 in that same cycle.
- Back-to-back commands: start asserted in the done cycle is accepted normally.
- Latency: start sampled at edge k; first out_valid high after edge k+1.
- Throughput: 1 coefficient/cycle with out_ready held high. N coefficients finish with the last handshake at edge k+N+1 and done high after edge k+N+2.
- Ordering: exactly length beats, in ascending address order, no duplicates or drops under any out_ready pattern.
- rd_data is assumed stable in the same cycle as rd_addr (distributed RAM); the block makes no write accesses.

Optional Feature:
Macro: MEM_COEF_READER_REVERSE_EN
- Defined:
  - Start latches base_addr+length-1 (mod 2**RAM_ADDR_BITS) as the first address.
  - Each load decrements rd_addr, wrapping 0 to 2047.
  - The stream therefore presents the window in descending order, used for polynomial reversal in inversion.
  - Handshake, counts, out_last, done and latency are identical to the default build.
- Undefined: ascending order only; no extra logic.

Test Plan:
1. RAM[i]=i+100, start base=5 length=4, out_ready=1 → beats 105,106,107,108 on consecutive cycles, out_last only on 108; done one cycle after the 108 handshake; busy low in that cycle.
2. Same command with out_ready toggling 1,0,0,1,0,1… → the same 4 values in order; out_data stable during every stall; no extra beats.
3. base=2046 length=4 → addresses 2046,2047,0,1; data matches RAM.
4. length=0 → no out_valid; done high the cycle after start. start issued during RUN → ignored, and the original stream completes unchanged.
5. rst_n pulled low after beat 2 of 6 → all outputs 0 asynchronously; no done. A new command after release streams correctly.
6. With MEM_COEF_READER_REVERSE_EN defined: base=10 length=3 → beats RAM[12],RAM[11],RAM[10], with out_last on RAM[10].
